rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
- Consumes the synchronized board reset and drives staged, ordered reset releases to the sound subsystem, e.g. codec interface, DSP datapath and host bus bridge.
- Also accepts software reset requests from the register block and returns a completion acknowledge.
- Guarantees a minimum reset assertion width and a fixed gap between stage releases, so each downstream block sees stable upstream logic before it leaves reset.

Parameters:
- N_STAGES, 3, number of independently released reset outputs; stage 0 is released first.
- HOLD_CYC, 16, minimum cycles all stages are held asserted before the first release; a value of 0 is treated as 1.
- GAP_CYC, 8, cycles between consecutive stage releases; a value of 0 is treated as 1.
- CNT_W, 8, counter width; HOLD_CYC, GAP_CYC and WDT_CYC must each be < 2^CNT_W.
- WDT_CYC, 200, watchdog timeout in cycles; only used when RST_SEQ_WDT_EN is defined.

Ports:
- baseclk, in, 1, system clock.
- reset_pre1, in, 1, reset: asynchronous, active-low, sampled on baseclk.
- sw_rst_req, in, 1, software reset request; a rising edge starts a sequence.
- sw_rst_ack, out, 1, one-cycle pulse when a software-initiated sequence completes.
- stage_rst_n, out, N_STAGES, per-stage active-low reset, registered.
- seq_busy, out, 1, high whenever the FSM is not in RUN.
- wdt_kick, in, 1, watchdog restart; present only with RST_SEQ_WDT_EN.
- wdt_fired, out, 1, sticky watchdog-trip flag; present only with RST_SEQ_WDT_EN.

Behaviour:
- Reset (reset_pre1 low):
  - state=HOLD, stage_rst_n=all 0, counter=0, stage index=0.
  - seq_busy=1, sw_rst_ack=0, sw-origin flag=0, req edge register=0, wdt_fired=0.
  - The reset takes effect immediately, mid-sequence included; all outputs are asynchronously forced to these values.
- FSM states: HOLD, RELEASE, RUN.
- HOLD:
  - All stages asserted; counter increments each cycle.
  - When counter == HOLD_CYC-1: counter clears, stage index=0, go to RELEASE.
  - The first stage therefore releases HOLD_CYC cycles after reset_pre1 rises.
- RELEASE:
  - On entry cycle, stage_rst_n[idx] goes to 1 (registered, visible the next cycle).
  - The counter then counts GAP_CYC cycles before the next stage index is released.
  - After stage N_STAGES-1 is released, go to RUN.
  - Stage k releases exactly HOLD_CYC + k*GAP_CYC cycles after sequence start.
  - Release is monotonic: a lower stage is never asserted while a higher stage is released.
- RUN:
  - All stage_rst_n=1, seq_busy=0.
  - On the cycle RUN is entered, if the sw-origin flag is set: sw_rst_ack=1 for exactly one cycle, and the flag clears.
- Software request:
  - sw_rst_req is edge-detected with a one-register delay; only a rising edge acts.
  - Rising edge in any state: all stage_rst_n forced to 0 next cycle, counter=0, go to HOLD, set the sw-origin flag.
  - A rising edge during HOLD or RELEASE restarts the full sequence.
  - Only one ack is issued, at final completion.
  - A level held high produces no further sequences.
- Simultaneous events:
  - A request edge on the same cycle as the final release wins: go to HOLD, no ack.
  - A request edge on the same cycle as the ack in RUN: the ack is still issued, and the new sequence starts the next cycle.
- Counter saturation is not possible; it is always cleared at terminal values.

Optional Feature:
- RST_SEQ_WDT_EN defined:
  - Adds wdt_kick, wdt_fired and a CNT_W watchdog counter.
  - The counter is active only in RUN and clears on wdt_kick or on entry to RUN.
  - Reaching WDT_CYC-1 behaves like a software request, but without setting the sw-origin flag, so no ack.
  - It also sets wdt_fired, which is sticky until reset_pre1.
  - A kick on the timeout cycle wins; no trip.
- RST_SEQ_WDT_EN undefined: no watchdog ports, logic or counter; behaviour is otherwise identical.

Decomposition:
- Shared package snd_rst_pkg:
  - FSM state enum (HOLD, RELEASE, RUN).
  - Default HOLD_CYC, GAP_CYC and WDT_CYC constants.
  - Stage index constants: STG_CODEC=0, STG_DSP=1, STG_BUS=2.
- One natural sub-module: rst_seq_wdt, the watchdog counter plus sticky flag, instantiated only under RST_SEQ_WDT_EN.

Test Plan:
- Power-on, defaults: release reset_pre1 at t0 -> stage_rst_n 000→001 at t0+16, 011 at t0+24, 111 at t0+32; seq_busy falls at t0+32; no ack.
- Software request in RUN: one-cycle sw_rst_req pulse -> stage_rst_n=000 next cycle, staged release repeats, sw_rst_ack pulses once when 111 is reached.
- Request during RELEASE, arriving after stage 0 released -> all stages reassert, full 16+8+8 timing restarts, exactly one ack at the end.
- sw_rst_req held high for 100 cycles -> exactly one sequence and one ack.
- reset_pre1 asserted mid-HOLD following a software request -> outputs immediately 000, sw-origin flag cleared, no ack after power-on sequence.
- RST_SEQ_WDT_EN, WDT_CYC=200: no kicks in RUN -> reset sequence starts on the 200th cycle, wdt_fired=1, no ack; a kick every 150 cycles -> never trips.

Source files
------------

// File: rtl/snd_rst_pkg.sv
// Shared state type, default timing constants and stage indices for the sound-subsystem reset sequencer.
package snd_rst_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN
   } seq_state_e;

   localparam int HOLD_CYC_DEF = 16;
   localparam int GAP_CYC_DEF  = 8;
   localparam int WDT_CYC_DEF  = 200;

   localparam int STG_CODEC = 0;
   localparam int STG_DSP   = 1;
   localparam int STG_BUS   = 2;

   // A zero cycle count would never hit its terminal value, so it is stretched to one.
   function automatic int eff_cyc(input int cyc);
      return (cyc < 1) ? 1 : cyc;
   endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Software-request handshake and staged reset outputs between the sequencer (master) and its consumers (slave).
interface rst_sequencer_if #(
   parameter int N_STAGES = 3
);
   logic                sw_rst_req;
   logic                sw_rst_ack;
   logic [N_STAGES-1:0] stage_rst_n;
   logic                seq_busy;

   modport master (
      input  sw_rst_req,
      output sw_rst_ack,
      output stage_rst_n,
      output seq_busy
   );

   modport slave (
      output sw_rst_req,
      input  sw_rst_ack,
      input  stage_rst_n,
      input  seq_busy
   );
endinterface

// File: rtl/rst_seq_wdt.sv
// Run-time watchdog for the reset sequencer: counts RUN cycles between kicks and raises a sticky trip flag.
module rst_seq_wdt
   import snd_rst_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int WDT_CYC = WDT_CYC_DEF
) (
   input  logic baseclk,
   input  logic reset_pre1,
   input  logic run,
   input  logic kick,
   output logic trip,
   output logic fired
);

   localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(eff_cyc(WDT_CYC) - 1);

   logic [CNT_W-1:0] cnt;

   // A kick on the timeout cycle takes precedence over the trip.
   assign trip = run & ~kick & (cnt == WDT_LAST);

   always_ff @(posedge baseclk or negedge reset_pre1) begin
      if (!reset_pre1) begin
         cnt   <= '0;
         fired <= 1'b0;
      end else begin
         if (!run || kick || trip) cnt <= '0;
         else                      cnt <= cnt + 1'b1;
         if (trip) fired <= 1'b1;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer for codec, DSP and host bridge; RST_SEQ_WDT_EN adds a RUN-time watchdog.
// N_STAGES must be at least 2.
module rst_sequencer
   import snd_rst_pkg::*;
#(
   parameter int N_STAGES = 3,
   parameter int HOLD_CYC = HOLD_CYC_DEF,
   parameter int GAP_CYC  = GAP_CYC_DEF,
   parameter int CNT_W    = 8,
   parameter int WDT_CYC  = WDT_CYC_DEF
) (
   input  logic             baseclk,
   input  logic             reset_pre1,
   rst_sequencer_if.master  seq
`ifdef RST_SEQ_WDT_EN
   ,
   input  logic             wdt_kick,
   output logic             wdt_fired
`endif
);

   localparam int               IDX_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(eff_cyc(HOLD_CYC) - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(eff_cyc(GAP_CYC) - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

   seq_state_e          state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [N_STAGES-1:0] stage_q;
   logic                busy_q;
   logic                ack_q;
   logic                sw_flag;
   logic                req_q;
   logic                req_edge;
   logic                wdt_trip;
   logic                restart;

   assign req_edge = seq.sw_rst_req & ~req_q;
   assign restart  = req_edge | wdt_trip;

`ifdef RST_SEQ_WDT_EN
   rst_seq_wdt #(
      .CNT_W   (CNT_W),
      .WDT_CYC (WDT_CYC)
   ) u_wdt (
      .baseclk    (baseclk),
      .reset_pre1 (reset_pre1),
      .run        (state == RUN),
      .kick       (wdt_kick),
      .trip       (wdt_trip),
      .fired      (wdt_fired)
   );
`else
   assign wdt_trip = 1'b0;
`endif

   // NOTE: state and outputs use non-blocking assignments with an asynchronous reset, so a
   // reset_pre1 assertion forces every output low/idle immediately, even mid-sequence.
   always_ff @(posedge baseclk or negedge reset_pre1) begin
      if (!reset_pre1) begin
         state   <= HOLD;
         cnt     <= '0;
         idx     <= '0;
         stage_q <= '0;
         busy_q  <= 1'b1;
         ack_q   <= 1'b0;
         sw_flag <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         req_q <= seq.sw_rst_req;
         ack_q <= 1'b0;
         if (restart) begin
            state   <= HOLD;
            cnt     <= '0;
            idx     <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            if (req_edge) sw_flag <= 1'b1;
         end else begin
            case (state)
               HOLD: begin
                  if (cnt == HOLD_LAST) begin
                     cnt     <= '0;
                     idx     <= '0;
                     stage_q <= N_STAGES'(1);
                     state   <= RELEASE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RELEASE: begin
                  // Shifting a one in from the bottom keeps the release order monotonic.
                  if (cnt == GAP_LAST) begin
                     cnt     <= '0;
                     idx     <= idx + 1'b1;
                     stage_q <= {stage_q[N_STAGES-2:0], 1'b1};
                     if ((idx + 1'b1) == IDX_LAST) begin
                        state   <= RUN;
                        busy_q  <= 1'b0;
                        ack_q   <= sw_flag;
                        sw_flag <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RUN: begin
                  stage_q <= '1;
               end
               default: begin
                  state <= HOLD;
               end
            endcase
         end
      end
   end

   assign seq.stage_rst_n = stage_q;
   assign seq.seq_busy    = busy_q;
   assign seq.sw_rst_ack  = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a timing model predicts every output change, a monitor checks them.
// Watchdog scenarios run only when RST_SEQ_WDT_EN is defined.
module tb_rst_sequencer;
   import snd_rst_pkg::*;

   localparam int N     = 3;
   localparam int HOLD  = 16;
   localparam int GAP   = 8;
   localparam int CW    = 8;
   localparam int WDT   = 200;
   localparam int TOTAL = HOLD + (N - 1) * GAP;

   typedef struct packed {
      logic [N-1:0] stage;
      logic         busy;
      logic         ack;
   } out_t;

   typedef struct {
      int   cyc;
      out_t val;
   } evt_t;

   localparam out_t RESET_VAL = '{stage: '0, busy: 1'b1, ack: 1'b0};

   logic baseclk    = 1'b0;
   logic reset_pre1 = 1'b0;
`ifdef RST_SEQ_WDT_EN
   logic wdt_kick = 1'b0;
   logic wdt_fired;
`endif

   rst_sequencer_if #(.N_STAGES(N)) sif ();

   rst_sequencer #(
      .N_STAGES (N),
      .HOLD_CYC (HOLD),
      .GAP_CYC  (GAP),
      .CNT_W    (CW),
      .WDT_CYC  (WDT)
   ) dut (
      .baseclk    (baseclk),
      .reset_pre1 (reset_pre1),
      .seq        (sif)
`ifdef RST_SEQ_WDT_EN
      ,
      .wdt_kick   (wdt_kick),
      .wdt_fired  (wdt_fired)
`endif
   );

   always #5 baseclk = ~baseclk;

   int   cyc;
   int   checks = 0;
   int   errors = 0;
   int   cur_start;
   bit   cur_sw;
   int   wdt_zero;
   bit   req_prev;
   bit   exp_fired;
   evt_t sbq[$];
   out_t mon_prev;
   out_t mon_cur;
   evt_t mon_ev;

   always @(posedge baseclk or negedge reset_pre1) begin
      if (!reset_pre1) cyc <= 0;
      else             cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: outputs t cycles into a sequence that began at 'start'.
   function automatic out_t exp_at(input int t, input int start, input bit sw);
      out_t o;
      int   d;
      d = t - start;
      for (int k = 0; k < N; k++) o.stage[k] = (d >= HOLD + k * GAP);
      o.busy = (d < TOTAL);
      o.ack  = sw && (d == TOTAL);
      return o;
   endfunction

   // Replace every not-yet-seen prediction with the trajectory of a sequence starting at cycle s.
   task automatic seq_restart(input int s, input bit sw, input out_t prev);
      out_t last;
      out_t v;
      evt_t e;
      last = prev;
      while (sbq.size() > 0 && sbq[$].cyc >= s) void'(sbq.pop_back());
      for (int t = s; t <= s + TOTAL + 1; t++) begin
         v = exp_at(t, s, sw);
         if (v !== last) begin
            e.cyc = t;
            e.val = v;
            sbq.push_back(e);
            last = v;
         end
      end
      cur_start = s;
      cur_sw    = sw;
      wdt_zero  = s + TOTAL;
   endtask

   // One cycle of stimulus, applied at the falling edge and acted on at the next rising edge.
   task automatic drive(input bit req, input bit kick);
      int   e;
      bit   rise;
      bit   trip;
      out_t prev;
      @(negedge baseclk);
      e    = cyc + 1;
      rise = req && !req_prev;
      req_prev = req;
      sif.sw_rst_req = req;
      trip = 1'b0;
`ifdef RST_SEQ_WDT_EN
      wdt_kick = kick;
      if (e > cur_start + TOTAL) begin
         if (kick)                      wdt_zero = e;
         else if (e == wdt_zero + WDT)  trip = 1'b1;
      end
`else
      if (kick) trip = 1'b0;
`endif
      if (rise || trip) begin
         prev = exp_at(e - 1, cur_start, cur_sw);
         seq_restart(e, rise || (cur_sw && e <= cur_start + TOTAL), prev);
         if (trip) exp_fired = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   // Advance so that the next drive() acts on rising edge 'target'.
   task automatic run_until(input int target);
      while (cyc + 2 < target) drive(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge baseclk);
      #2;
      reset_pre1     = 1'b0;
      sif.sw_rst_req = 1'b0;
      req_prev       = 1'b0;
`ifdef RST_SEQ_WDT_EN
      wdt_kick = 1'b0;
`endif
      #1;
      check("reset_stage", sif.stage_rst_n, '0);
      check("reset_busy", sif.seq_busy, 1'b1);
      check("reset_ack", sif.sw_rst_ack, 1'b0);
      exp_fired = 1'b0;
`ifdef RST_SEQ_WDT_EN
      check("reset_wdt_fired", wdt_fired, exp_fired);
`endif
      sbq.delete();
      mon_prev = RESET_VAL;
      repeat (2) @(negedge baseclk);
      reset_pre1 = 1'b1;
      cur_sw = 1'b0;
      seq_restart(0, 1'b0, RESET_VAL);
   endtask

   // Monitor: every output change must match the oldest outstanding prediction.
   always @(posedge baseclk) begin
      #1;
      if (reset_pre1) begin
         mon_cur = '{stage: sif.stage_rst_n, busy: sif.seq_busy, ack: sif.sw_rst_ack};
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            mon_ev = sbq.pop_front();
            check("missed_event_cycle", cyc, mon_ev.cyc);
         end
         if (mon_cur !== mon_prev) begin
            if (sbq.size() == 0) begin
               check("unexpected_change", mon_cur, mon_prev);
            end else begin
               mon_ev = sbq.pop_front();
               check("event_cycle", cyc, mon_ev.cyc);
               check("event_value", mon_cur, mon_ev.val);
            end
            mon_prev = mon_cur;
         end
      end
   end

   initial begin
      bit req;
      bit kick;
      int s;
      sif.sw_rst_req = 1'b0;

      // Power-on sequence with no acknowledge.
      do_reset();
      idle(TOTAL + 10);

      // Single software pulse in RUN.
      drive(1'b1, 1'b0);
      idle(TOTAL + 10);

      // Second request after stage 0 has been released restarts the full sequence.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      idle(HOLD + 3);
      drive(1'b1, 1'b0);
      idle(TOTAL + 10);

      // Level held high gives one sequence only.
      repeat (100) drive(1'b1, 1'b0);
      idle(10);

      // Request edge on the final-release cycle wins; then one on the ack cycle.
      drive(1'b1, 1'b0);
      s = cur_start;
      drive(1'b0, 1'b0);
      run_until(s + TOTAL);
      drive(1'b1, 1'b0);
      s = cur_start;
      drive(1'b0, 1'b0);
      run_until(s + TOTAL + 1);
      drive(1'b1, 1'b0);
      idle(TOTAL + 10);

      // Reset mid-HOLD after a software request: no ack after the power-on sequence.
      drive(1'b1, 1'b0);
      idle(5);
      do_reset();
      idle(TOTAL + 10);

      // Random request levels and occasional kicks.
      req = 1'b0;
      repeat (400) begin
         if ($urandom_range(0, 19) == 0) req = !req;
         kick = ($urandom_range(0, 249) == 0);
         drive(req, kick);
      end
      idle(TOTAL + 10);

`ifdef RST_SEQ_WDT_EN
      // No kicks: watchdog trips WDT cycles into RUN, without an ack.
      do_reset();
      run_until(TOTAL + WDT + TOTAL + 5);
      check("wdt_fired_after_trip", wdt_fired, exp_fired);
      check("wdt_fired_expected", {31'd0, exp_fired}, 32'd1);
      // Kicks every 150 cycles keep it quiet; the flag stays sticky.
      repeat (5) begin
         repeat (149) drive(1'b0, 1'b0);
         drive(1'b0, 1'b1);
      end
      check("wdt_fired_sticky", wdt_fired, exp_fired);
      do_reset();
      idle(TOTAL + 10);
`endif

      for (int i = 0; i < 100 && sbq.size() > 0; i++) drive(1'b0, 1'b0);
      check("scoreboard_drained", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
